// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, function
// codes, ALU control codes, FSM state encodings and the control bundle type.
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // aluop encodings between FSM and ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // FSM state encodings (4 bits is the minimum width)
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  // Per-cycle control bundle produced by the FSM
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  // True when funct is one of the supported R-type operations
  function automatic logic funct_known(input logic [5:0] f);
    logic ok;
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
      default:                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps aluop and funct to the 3-bit ALU control code and flags
// unsupported R-type function codes.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       bad_funct_o
);

  // Select the ALU operation; funct only matters when aluop asks for it
  always_comb begin
    alucontrol_o = ALU_ADD;
    bad_funct_o  = 1'b0;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: begin
            alucontrol_o = ALU_ADD;
            bad_funct_o  = 1'b1;
          end
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM. Moore machine: every output is decoded from
// the registered state (plus op/funct for illegal detection), except pcen,
// which also folds in the ALU zero flag for taken branches.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int STATE_W      = 4,
  parameter bit SUPPORT_ADDI = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [STATE_W-1:0] ST_FETCH   = STATE_W'(S_FETCH);
  localparam logic [STATE_W-1:0] ST_DECODE  = STATE_W'(S_DECODE);
  localparam logic [STATE_W-1:0] ST_MEMADR  = STATE_W'(S_MEMADR);
  localparam logic [STATE_W-1:0] ST_MEMRD   = STATE_W'(S_MEMRD);
  localparam logic [STATE_W-1:0] ST_MEMWB   = STATE_W'(S_MEMWB);
  localparam logic [STATE_W-1:0] ST_MEMWR   = STATE_W'(S_MEMWR);
  localparam logic [STATE_W-1:0] ST_RTYPEEX = STATE_W'(S_RTYPEEX);
  localparam logic [STATE_W-1:0] ST_RTYPEWB = STATE_W'(S_RTYPEWB);
  localparam logic [STATE_W-1:0] ST_BEQEX   = STATE_W'(S_BEQEX);
  localparam logic [STATE_W-1:0] ST_ADDIEX  = STATE_W'(S_ADDIEX);
  localparam logic [STATE_W-1:0] ST_ADDIWB  = STATE_W'(S_ADDIWB);
  localparam logic [STATE_W-1:0] ST_JEX     = STATE_W'(S_JEX);

  logic [STATE_W-1:0] state_q, state_d;
  ctrl_t              ctrl_s;
  logic               bad_funct_s;

  // Next-state and per-state control decode; unused encodings fall back to FETCH
  always_comb begin
    state_d = ST_FETCH;
    ctrl_s  = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl_s.alusrcb = 2'b01;
        ctrl_s.irwrite = 1'b1;
        ctrl_s.pcwrite = 1'b1;
        state_d        = ST_DECODE;
      end
      ST_DECODE: begin
        ctrl_s.alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_RTYPEEX;
          OP_BEQ:       state_d = ST_BEQEX;
          OP_J:         state_d = ST_JEX;
          OP_ADDI: begin
            if (SUPPORT_ADDI) begin
              state_d = ST_ADDIEX;
            end else begin
              state_d        = ST_FETCH;
              ctrl_s.illegal = 1'b1;
            end
          end
          default: begin
            state_d        = ST_FETCH;
            ctrl_s.illegal = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = 2'b10;
        if (op == OP_SW) begin
          state_d = ST_MEMWR;
        end else begin
          state_d = ST_MEMRD;
        end
      end
      ST_MEMRD: begin
        ctrl_s.iord = 1'b1;
        state_d     = ST_MEMWB;
      end
      ST_MEMWB: begin
        ctrl_s.memtoreg = 1'b1;
        ctrl_s.regwrite = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_MEMWR: begin
        ctrl_s.iord     = 1'b1;
        ctrl_s.memwrite = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_RTYPEEX: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.aluop   = ALUOP_FUNCT;
        state_d        = ST_RTYPEWB;
      end
      ST_RTYPEWB: begin
        ctrl_s.regdst = 1'b1;
        // A bad funct suppresses the write and raises illegal_op instead
        if (funct_known(funct)) begin
          ctrl_s.regwrite = 1'b1;
        end else begin
          ctrl_s.illegal = 1'b1;
        end
        state_d = ST_FETCH;
      end
      ST_BEQEX: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.aluop   = ALUOP_SUB;
        ctrl_s.pcsrc   = 2'b01;
        ctrl_s.branch  = 1'b1;
        state_d        = ST_FETCH;
      end
      ST_ADDIEX: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = 2'b10;
        state_d        = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        ctrl_s.regwrite = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_JEX: begin
        ctrl_s.pcsrc   = 2'b10;
        ctrl_s.pcwrite = 1'b1;
        state_d        = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
        ctrl_s  = '0;
      end
    endcase
  end

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  alu_decoder u_alu_decoder (
    .aluop_i      (ctrl_s.aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol),
    .bad_funct_o  (bad_funct_s)
  );

  // Write enables and illegal_op are held low while reset is asserted so
  // nothing commits on the reset edge or during an aborted instruction.
  assign pcen       = ~reset & (ctrl_s.pcwrite | (ctrl_s.branch & zero));
  assign memwrite   = ~reset & ctrl_s.memwrite;
  assign irwrite    = ~reset & ctrl_s.irwrite;
  assign regwrite   = ~reset & ctrl_s.regwrite;
  assign illegal_op = ~reset & ctrl_s.illegal;
  assign iord       = ctrl_s.iord;
  assign memtoreg   = ctrl_s.memtoreg;
  assign regdst     = ctrl_s.regdst;
  assign alusrca    = ctrl_s.alusrca;
  assign alusrcb    = ctrl_s.alusrcb;
  assign pcsrc      = ctrl_s.pcsrc;
  assign state_o    = state_q;

  // bad_funct from the decoder duplicates the RTYPEWB check above; it is only
  // meaningful in RTYPEEX and is kept for datapath debug visibility.
  logic unused_s;
  assign unused_s = bad_funct_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed instructions followed by a
// randomized instruction stream, each cycle compared against a per-instruction
// schedule derived from the instruction class and cycle number.
module tb_multicycle_controller;
  import mips_pkg::*;

  logic       clk, reset, zero;
  logic [5:0] op, funct;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op;
  logic [3:0] state_o;

  int tests = 0;
  int fails = 0;

  multicycle_controller #(.STATE_W(4), .SUPPORT_ADDI(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal_op(illegal_op), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_RTYPE) ||
           (o == OP_BEQ) || (o == OP_ADDI) || (o == OP_J);
  endfunction

  // {valid, alu code} for an R-type funct
  function automatic logic [3:0] fdec(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic int latency(input logic [5:0] o);
    if (o == OP_LW) return 5;
    if (o == OP_SW || o == OP_RTYPE || o == OP_ADDI) return 4;
    if (o == OP_BEQ || o == OP_J) return 3;
    return 2;
  endfunction

  // Expected state and output bundle for cycle k of an instruction
  task automatic model(input logic [5:0] o, input logic [5:0] f, input int k, input logic z,
                       output logic [3:0] st, output logic [15:0] b);
    logic pc, mw, irw, rw, io, m2r, rd, asa, ill;
    logic [1:0] asb, ps;
    logic [2:0] alu;
    logic [3:0] fm;
    {pc, mw, irw, rw, io, m2r, rd, asa, ill} = 9'b0;
    asb = 2'b00; ps = 2'b00; alu = 3'b010; st = 4'hF;
    fm = fdec(f);
    if (k == 0) begin
      st = S_FETCH; irw = 1'b1; pc = 1'b1; asb = 2'b01;
    end else if (k == 1) begin
      st = S_DECODE; asb = 2'b11; ill = !is_legal(o);
    end else if (o == OP_LW || o == OP_SW) begin
      if (k == 2) begin st = S_MEMADR; asa = 1'b1; asb = 2'b10; end
      else if (o == OP_SW) begin st = S_MEMWR; io = 1'b1; mw = 1'b1; end
      else if (k == 3) begin st = S_MEMRD; io = 1'b1; end
      else begin st = S_MEMWB; m2r = 1'b1; rw = 1'b1; end
    end else if (o == OP_RTYPE) begin
      if (k == 2) begin st = S_RTYPEEX; asa = 1'b1; alu = fm[2:0]; end
      else begin st = S_RTYPEWB; rd = 1'b1; rw = fm[3]; ill = !fm[3]; end
    end else if (o == OP_BEQ) begin
      st = S_BEQEX; asa = 1'b1; alu = 3'b110; ps = 2'b01; pc = z;
    end else if (o == OP_ADDI) begin
      if (k == 2) begin st = S_ADDIEX; asa = 1'b1; asb = 2'b10; end
      else begin st = S_ADDIWB; rw = 1'b1; end
    end else begin
      st = S_JEX; ps = 2'b10; pc = 1'b1;
    end
    b = {pc, mw, irw, rw, io, m2r, rd, asa, asb, ps, alu, ill};
  endtask

  function automatic logic [15:0] observed();
    return {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
            alusrcb, pcsrc, alucontrol, illegal_op};
  endfunction

  // Run one instruction from its FETCH cycle. zmode: 0/1 force zero, 2 random.
  // abort_at >= 0 asserts reset in that cycle and checks the abort.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode, input int abort_at);
    logic [3:0]  st;
    logic [15:0] b;
    for (int k = 0; k < latency(o); k++) begin
      @(negedge clk);
      op = o; funct = f;
      zero = (zmode == 2) ? 1'($urandom_range(1)) : 1'(zmode);
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        model(o, f, k, zero, st, b);
        chk($sformatf("abort state op=%h k=%0d", o, k), 32'(state_o), 32'(st));
        chk($sformatf("abort enables op=%h k=%0d", o, k),
            32'({pcen, memwrite, irwrite, regwrite, illegal_op}), 32'd0);
        @(posedge clk); #1;
        chk("abort next state", 32'(state_o), 32'(S_FETCH));
        chk("abort enables after edge",
            32'({pcen, memwrite, irwrite, regwrite, illegal_op}), 32'd0);
        reset = 1'b0;
        return;
      end
      #1;
      model(o, f, k, zero, st, b);
      chk($sformatf("state op=%h fn=%h k=%0d", o, f, k), 32'(state_o), 32'(st));
      chk($sformatf("outputs op=%h fn=%h k=%0d z=%0b", o, f, k, zero), 32'(observed()), 32'(b));
    end
  endtask

  initial begin
    logic [5:0] rop, rfn;
    logic [5:0] fns [5];
    logic [5:0] ops [6];
    fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
    reset = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0;

    // Reset held for three edges: FETCH with every enable low
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("reset state edge %0d", i), 32'(state_o), 32'(S_FETCH));
      chk($sformatf("reset enables edge %0d", i),
          32'({pcen, memwrite, irwrite, regwrite, illegal_op}), 32'd0);
    end
    reset = 1'b0;

    // Directed instructions
    run_instr(OP_LW,    6'b000000, 2, -1);
    run_instr(OP_SW,    6'b000000, 2, -1);
    run_instr(OP_RTYPE, FN_SLT,    2, -1);
    run_instr(OP_RTYPE, FN_SUB,    2, -1);
    run_instr(OP_BEQ,   6'b000000, 1, -1);
    run_instr(OP_BEQ,   6'b000000, 0, -1);
    run_instr(OP_J,     6'b000000, 2, -1);
    run_instr(OP_ADDI,  6'b000000, 2, -1);
    run_instr(6'b111111, 6'b000000, 2, -1);
    run_instr(OP_RTYPE, 6'b000000, 2, -1);
    run_instr(OP_SW,    6'b000000, 2, 3);
    run_instr(OP_LW,    6'b000000, 2, 2);
    run_instr(OP_LW,    6'b000000, 2, -1);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(7) == 0) begin
        rop = 6'($urandom_range(63));
        while (is_legal(rop)) rop = 6'($urandom_range(63));
      end else begin
        rop = ops[$urandom_range(5)];
      end
      if ($urandom_range(4) == 0) rfn = 6'($urandom_range(63));
      else rfn = fns[$urandom_range(4)];
      run_instr(rop, rfn, 2, ($urandom_range(15) == 0) ? int'($urandom_range(latency(rop) - 1)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
